seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed driver for four 7-segment digits, placed between the UART control logic and the board display pins. It owns a clock divider that produces a scan-rate enable pulse and a 2-bit digit-select counter that advances on each pulse. It also contains a hex-to-segment decoder, a digit multiplexer and an anode decoder. The UART top feeds it the last received byte on the low two digits and zero on the upper two.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_FREQ, 1000, digit-advance rate in Hz.
- DIV = CLK_FREQ/SCAN_FREQ, derived, not overridable; must be ≥2, elaboration error otherwise.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 freezes divider and digit select.
- value  in  16  four hex nibbles; digit k shows value[4k+3:4k].
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- an  out  8  active-low digit enables; an[7:4] is always 4'hF.

## Operation
- Divider: counter div_cnt, width $clog2(DIV).
  - When en=1 it counts 0..DIV-1 and wraps.
  - tick=1 for exactly one clk cycle when div_cnt==DIV-1 and en=1.
- Select: 2-bit sel, incremented on tick, wrapping 3→0. Digit 0 is shown first after reset.
- Decode: nibble = value[4·sel+3 : 4·sel], converted with the fixed active-low table:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- Anode: an[3:0] = ~(4'b0001 << sel), an[7:4] = 4'hF.
- seg and an are registered: they reflect sel and value as sampled on the previous clk edge.
- value is sampled every cycle, so a change on it appears on seg within 1 cycle even mid-scan.

## Timing
- Reset (rst=1 at a clk edge):
  - div_cnt=0, sel=0, seg=8'hFF, an=8'hFF (all blank).
  - rst has priority over en.
- First edge after reset release: an=8'hFE, seg=decode(value[3:0]).
- tick asserts DIV cycles after reset release, assuming en=1 throughout.
  - sel advances on that same edge.
  - seg/an show the new digit one edge later.
- Steady state: each digit is active for DIV consecutive cycles; the full refresh period is 4·DIV cycles.
- en=0:
  - div_cnt and sel hold.
  - seg/an keep tracking value for the current digit.
  - Resuming continues the count from where it stopped; no restart.
- Reset asserted mid-scan blanks the outputs on the next edge and restarts at digit 0.

## Structure
- Package seg_scan_pkg:
  - the 16-entry segment pattern constant array;
  - SEG_BLANK = 8'hFF;
  - AN_IDLE_HI = 4'hF.
- Sub-module hex7seg: purely combinational 4-bit to 8-bit table lookup, one instance driven by the muxed nibble.
- Divider, select counter, mux and anode decode stay inline in the top.

## Test plan
Use CLK_FREQ=8 and SCAN_FREQ=2, so DIV=4, for all scenarios.
- Reset: hold rst 3 cycles with value=16'h1234 → seg=FF, an=FF during reset; the first edge after release gives an=FE, seg=99 (digit "4").
- Scan order: value=16'hA5C0, en=1 → (an,seg) sequence FE/C0, FD/C6, FB/92, F7/88, each held exactly 4 cycles, then back to FE.
- Full table: sel held at 0 via en=0; step value[3:0] through 0..F one per cycle → seg matches all 16 codes, one cycle late.
- Enable freeze: drop en for 10 cycles while on digit 2 → an stays FB; after en returns, the digit lasts only its remaining cycles, not a fresh 4.
- Mid-scan reset: assert rst while on digit 3 → next edge gives seg=FF, an=FF; after release, scanning restarts at an=FE with the full 4-cycle dwell.
- UART usage: value={8'h00, 8'h3F} → digits show F, 3, 0, 0 (seg 8E, B0, C0, C0); an[7:4]=F and seg[7]=1 at all times.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the 7-segment scan driver.
// Active-low segment patterns, blanking values and lookup helper.
package seg_scan_pkg;

    // All segments off, decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Upper four anodes are never driven on this board.
    localparam logic [3:0] AN_IDLE_HI = 4'hF;

    // Active-low {dp,g,f,e,d,c,b,a}; element k is the glyph for hex k.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// hex7seg: combinational hex nibble to active-low segment pattern.
// dp is off in every table entry.
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Plain table lookup; no state.
    always_comb begin
        seg = seg_lookup(nibble);
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: four-digit time-multiplexed 7-segment driver.
// Divider makes a scan tick; sel walks digits; outputs are registered.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SCAN_FREQ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("seg_scan_display: CLK_FREQ/SCAN_FREQ must be >= 2");
    end

    logic [DW-1:0] div_cnt;
    logic [1:0]    sel;
    logic          tick;
    logic [3:0]    nibble;
    logic [7:0]    seg_dec;
    logic [3:0]    an_lo;

    // One-cycle scan pulse at the end of each divider period.
    always_comb begin
        tick = en && (div_cnt == DIV_LAST);
    end

    // Pick the nibble of the digit currently selected.
    always_comb begin
        nibble = value[3:0];
        case (sel)
            2'd0: nibble = value[3:0];
            2'd1: nibble = value[7:4];
            2'd2: nibble = value[11:8];
            2'd3: nibble = value[15:12];
            default: nibble = value[3:0];
        endcase
    end

    // One-hot active-low anode for the selected digit.
    always_comb begin
        an_lo = 4'hF;
        case (sel)
            2'd0: an_lo = 4'b1110;
            2'd1: an_lo = 4'b1101;
            2'd2: an_lo = 4'b1011;
            2'd3: an_lo = 4'b0111;
            default: an_lo = 4'hF;
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Divider, digit select and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sel     <= 2'd0;
            seg     <= SEG_BLANK;
            an      <= {AN_IDLE_HI, 4'hF};
        end else begin
            if (en) begin
                if (tick) begin
                    div_cnt <= '0;
                    sel     <= sel + 2'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            seg <= seg_dec;
            an  <= {AN_IDLE_HI, an_lo};
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of the 4-digit scan driver.
// DIV = 8/2 = 4 clk cycles per digit.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [7:0]  seg;
    logic [7:0]  an;

    int total;
    int bad;

    logic [7:0] lut [16];
    logic [7:0] an_exp [4];
    logic [7:0] sg_exp [4];

    seg_scan_display #(
        .CLK_FREQ  (8),
        .SCAN_FREQ (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .value (value),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) nxt();
        chk("rst_seg", {8'h0, seg}, 16'h00FF);
        chk("rst_an", {8'h0, an}, 16'h00FF);
        rst = 1'b0;
    endtask

    // Walk one full refresh plus the wrap back to digit 0.
    task automatic scan_check(input string tag);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                nxt();
                chk({tag, "_an"}, {8'h0, an}, {8'h0, an_exp[d]});
                chk({tag, "_seg"}, {8'h0, seg}, {8'h0, sg_exp[d]});
                chk({tag, "_hi"}, {12'h0, an[7:4], 3'b0, seg[7]},
                    {12'h0, 4'hF, 3'b0, 1'b1});
            end
        end
        nxt();
        chk({tag, "_wrap_an"}, {8'h0, an}, 16'h00FE);
        chk({tag, "_wrap_seg"}, {8'h0, seg}, {8'h0, sg_exp[0]});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        an_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

        // Reset held 3 cycles, rst beats en.
        rst = 1'b1;
        en = 1'b1;
        value = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("hold_seg", {8'h0, seg}, 16'h00FF);
            chk("hold_an", {8'h0, an}, 16'h00FF);
        end
        rst = 1'b0;
        nxt();
        chk("first_an", {8'h0, an}, 16'h00FE);
        chk("first_seg", {8'h0, seg}, 16'h0099);

        // Scan order and dwell.
        value = 16'hA5C0;
        do_reset();
        sg_exp = '{8'hC0, 8'hC6, 8'h92, 8'h88};
        scan_check("scan");

        // Full decode table with sel frozen at 0.
        en = 1'b0;
        do_reset();
        value = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            value[3:0] = 4'(i);
            nxt();
            chk("table_seg", {8'h0, seg}, {8'h0, lut[i]});
            chk("table_an", {8'h0, an}, 16'h00FE);
        end

        // Freeze on digit 2, value change while frozen, then resume.
        en = 1'b1;
        value = 16'hA5C0;
        do_reset();
        repeat (10) nxt();
        chk("frz_pre_an", {8'h0, an}, 16'h00FB);
        en = 1'b0;
        for (int i = 11; i <= 20; i++) begin
            nxt();
            chk("frz_an", {8'h0, an}, 16'h00FB);
            if (i == 15) value = 16'h0700;
            if (i == 16) chk("frz_seg", {8'h0, seg}, 16'h00F8);
        end
        en = 1'b1;
        nxt();
        chk("res21_an", {8'h0, an}, 16'h00FB);
        nxt();
        chk("res22_an", {8'h0, an}, 16'h00FB);
        nxt();
        chk("res23_an", {8'h0, an}, 16'h00F7);
        chk("res23_seg", {8'h0, seg}, 16'h00C0);

        // Reset mid-scan on digit 3.
        rst = 1'b1;
        nxt();
        chk("mid_seg", {8'h0, seg}, 16'h00FF);
        chk("mid_an", {8'h0, an}, 16'h00FF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("mid_dwell_an", {8'h0, an}, 16'h00FE);
        end
        chk("mid_dwell_seg", {8'h0, seg}, 16'h00C0);
        nxt();
        chk("mid_next_an", {8'h0, an}, 16'h00FD);

        // UART byte on low two digits.
        value = {8'h00, 8'h3F};
        do_reset();
        sg_exp = '{8'h8E, 8'hB0, 8'hC0, 8'hC0};
        scan_check("uart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
